// File: rtl/rng_pkg.sv
// Shared definitions for the randomizer and its health monitor:
// monitor FSM states and the default symbol width and test cutoffs.
package rng_pkg;

   typedef enum logic [1:0] {
      S_WARM = 2'd0,
      S_OK   = 2'd1,
      S_FAIL = 2'd2
   } hm_state_t;

   localparam int SYM_W_DEF      = 2;
   localparam int RCT_CUTOFF_DEF = 8;
   localparam int APT_WINDOW_DEF = 64;
   localparam int APT_CUTOFF_DEF = 40;

endpackage

// File: rtl/rng_health_monitor_if.sv
// Symbol stream into the health monitor and its status flags back out.
// The master side drives the stream; the slave side is the monitor.
interface rng_health_monitor_if
   import rng_pkg::*;
#(
   parameter int SYM_W      = SYM_W_DEF,
   parameter int APT_WINDOW = APT_WINDOW_DEF
);
   localparam int WIN_W = $clog2(APT_WINDOW + 1);

   logic             i_en;
   logic [SYM_W-1:0] i_r;
   logic             i_clear;
   logic             o_ready;
   logic             o_rct_fail;
   logic             o_apt_fail;
   logic             o_healthy;
   logic [WIN_W-1:0] o_win_cnt;

   modport master (
      output i_en, i_r, i_clear,
      input  o_ready, o_rct_fail, o_apt_fail, o_healthy, o_win_cnt
   );

   modport slave (
      input  i_en, i_r, i_clear,
      output o_ready, o_rct_fail, o_apt_fail, o_healthy, o_win_cnt
   );
endinterface

// File: rtl/rng_apt_window.sv
// Adaptive-proportion window: tracks the reference symbol, window and match
// counts. Close/trip pulses describe the sample being consumed this cycle.
module rng_apt_window
   import rng_pkg::*;
#(
   parameter int SYM_W      = SYM_W_DEF,
   parameter int APT_WINDOW = APT_WINDOW_DEF,
   parameter int APT_CUTOFF = APT_CUTOFF_DEF,
   localparam int WIN_W     = $clog2(APT_WINDOW + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_clear,
   input  logic             i_sample,
   input  logic [SYM_W-1:0] i_r,
   output logic [WIN_W-1:0] o_win_cnt,
   output logic             o_close,
   output logic             o_apt_trip
);
   logic [SYM_W-1:0] ref_reg, ref_next;
   logic [WIN_W-1:0] win_reg, win_next, win_inc;
   logic [WIN_W-1:0] match_reg, match_next;

   always_comb begin
      ref_next   = ref_reg;
      win_next   = win_reg;
      match_next = match_reg;
      win_inc    = win_reg;
      o_close    = 1'b0;
      o_apt_trip = 1'b0;
      if (i_sample) begin
         if (win_reg == '0) begin
            ref_next   = i_r;
            match_next = WIN_W'(1);
            win_inc    = WIN_W'(1);
         end else begin
            // Window never rests at APT_WINDOW, so this increment cannot wrap.
            win_inc = win_reg + WIN_W'(1);
            if (i_r == ref_reg && match_reg != WIN_W'(APT_WINDOW))
               match_next = match_reg + WIN_W'(1);
         end
         o_apt_trip = (match_next == WIN_W'(APT_CUTOFF));
         o_close    = (win_inc == WIN_W'(APT_WINDOW));
         win_next   = o_close ? '0 : win_inc;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ref_reg   <= '0;
         win_reg   <= '0;
         match_reg <= '0;
      end else if (i_clear) begin
         ref_reg   <= '0;
         win_reg   <= '0;
         match_reg <= '0;
      end else begin
         ref_reg   <= ref_next;
         win_reg   <= win_next;
         match_reg <= match_next;
      end
   end

   assign o_win_cnt = win_reg;
endmodule

// File: rtl/rng_health_monitor.sv
// Continuous health tests on the random symbol stream: repetition count in
// this module, adaptive proportion in rng_apt_window, plus the status FSM.
module rng_health_monitor
   import rng_pkg::*;
#(
   parameter int SYM_W      = SYM_W_DEF,
   parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
   parameter int APT_WINDOW = APT_WINDOW_DEF,
   parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   rng_health_monitor_if.slave  bus
);
   localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
   localparam int WIN_W = $clog2(APT_WINDOW + 1);

   hm_state_t        state_reg, state_next;
   logic [RUN_W-1:0] run_reg, run_next;
   logic [SYM_W-1:0] last_reg, last_next;
   logic             seen_reg, seen_next;
   logic             rct_reg, rct_next;
   logic             apt_reg, apt_next;
   logic             ready_reg, ready_next;
   logic             healthy_reg, healthy_next;
   logic             rct_trip;
   logic             consume;
   logic             win_close;
   logic             apt_trip;
   logic [WIN_W-1:0] win_cnt;

   assign consume = bus.i_en && !bus.i_clear && (state_reg != S_FAIL);

   rng_apt_window #(
      .SYM_W      (SYM_W),
      .APT_WINDOW (APT_WINDOW),
      .APT_CUTOFF (APT_CUTOFF)
   ) u_apt (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_clear    (bus.i_clear),
      .i_sample   (consume),
      .i_r        (bus.i_r),
      .o_win_cnt  (win_cnt),
      .o_close    (win_close),
      .o_apt_trip (apt_trip)
   );

   always_comb begin
      state_next = state_reg;
      run_next   = run_reg;
      last_next  = last_reg;
      seen_next  = seen_reg;
      rct_next   = rct_reg;
      apt_next   = apt_reg;
      ready_next = ready_reg;
      rct_trip   = 1'b0;
      if (consume) begin
         // seen_reg distinguishes a genuine first sample from a repeat of the reset value 0.
         if (!seen_reg || bus.i_r != last_reg)
            run_next = RUN_W'(1);
         else if (run_reg != RUN_W'(RCT_CUTOFF))
            run_next = run_reg + RUN_W'(1);
         last_next = bus.i_r;
         seen_next = 1'b1;
         rct_trip  = (run_next == RUN_W'(RCT_CUTOFF));
         rct_next  = rct_reg | rct_trip;
         apt_next  = apt_reg | apt_trip;
         if (rct_trip || apt_trip) begin
            state_next = S_FAIL;
         end else if (state_reg == S_WARM && win_close) begin
            state_next = S_OK;
            ready_next = 1'b1;
         end
      end
      healthy_next = ready_next && !rct_next && !apt_next;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg   <= S_WARM;
         run_reg     <= '0;
         last_reg    <= '0;
         seen_reg    <= 1'b0;
         rct_reg     <= 1'b0;
         apt_reg     <= 1'b0;
         ready_reg   <= 1'b0;
         healthy_reg <= 1'b0;
      end else if (bus.i_clear) begin
         state_reg   <= S_WARM;
         run_reg     <= '0;
         last_reg    <= '0;
         seen_reg    <= 1'b0;
         rct_reg     <= 1'b0;
         apt_reg     <= 1'b0;
         ready_reg   <= 1'b0;
         healthy_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         run_reg     <= run_next;
         last_reg    <= last_next;
         seen_reg    <= seen_next;
         rct_reg     <= rct_next;
         apt_reg     <= apt_next;
         ready_reg   <= ready_next;
         healthy_reg <= healthy_next;
      end
   end

   assign bus.o_ready    = ready_reg;
   assign bus.o_rct_fail = rct_reg;
   assign bus.o_apt_fail = apt_reg;
   assign bus.o_healthy  = healthy_reg;
   assign bus.o_win_cnt  = win_cnt;
endmodule

// File: tb/tb_rng_health_monitor.sv
// Directed bench for rng_health_monitor: a behavioural model queues the expected
// outputs for every driven cycle and they are compared one cycle later.
module tb_rng_health_monitor;
   import rng_pkg::*;

   logic clk;
   logic rst_n;

   rng_health_monitor_if bus ();

   rng_health_monitor dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ready;
      logic       rct;
      logic       apt;
      logic       healthy;
      logic [6:0] win;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // behavioural model state
   int m_run, m_last, m_seen, m_win, m_match, m_ref, m_state;
   bit m_ready, m_rct, m_apt, m_healthy;

   task automatic model_reset();
      m_run = 0; m_last = 0; m_seen = 0; m_win = 0; m_match = 0; m_ref = 0;
      m_state = 0; m_ready = 0; m_rct = 0; m_apt = 0; m_healthy = 0;
   endtask

   task automatic model_step(input bit en, input int r, input bit clr);
      bit rt, at, closed;
      if (clr) begin
         model_reset();
      end else if (en && m_state != 2) begin
         if (m_seen != 0 && r == m_last) m_run = (m_run + 1 > 8) ? 8 : m_run + 1;
         else m_run = 1;
         m_last = r;
         m_seen = 1;
         if (m_win == 0) begin
            m_ref = r; m_match = 1; m_win = 1;
         end else begin
            m_win++;
            if (r == m_ref) m_match++;
         end
         closed = (m_win == 64);
         if (closed) m_win = 0;
         rt = (m_run == 8);
         at = (m_match == 40);
         if (rt) m_rct = 1;
         if (at) m_apt = 1;
         if (rt || at) m_state = 2;
         else if (m_state == 0 && closed) begin
            m_state = 1;
            m_ready = 1;
         end
      end
      m_healthy = m_ready && !m_rct && !m_apt;
   endtask

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic step(input bit en, input logic [1:0] r, input bit clr);
      exp_t e, got;
      bus.i_en    = en;
      bus.i_r     = r;
      bus.i_clear = clr;
      model_step(en, int'(r), clr);
      e.ready = m_ready; e.rct = m_rct; e.apt = m_apt; e.healthy = m_healthy;
      e.win   = 7'(m_win);
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.i_en    = 1'b0;
      bus.i_clear = 1'b0;
      got = sb.pop_front();
      chk("sb_ready",   {6'd0, bus.o_ready},    {6'd0, got.ready});
      chk("sb_rct",     {6'd0, bus.o_rct_fail}, {6'd0, got.rct});
      chk("sb_apt",     {6'd0, bus.o_apt_fail}, {6'd0, got.apt});
      chk("sb_healthy", {6'd0, bus.o_healthy},  {6'd0, got.healthy});
      chk("sb_win",     bus.o_win_cnt,          got.win);
      $display("t=%0t en=%0b r=%0d clr=%0b -> ready=%0b rct=%0b apt=%0b healthy=%0b win=%0d",
               $time, en, r, clr, bus.o_ready, bus.o_rct_fail, bus.o_apt_fail,
               bus.o_healthy, bus.o_win_cnt);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},   {6'd0, bus.o_ready},    7'd0);
      chk({tag, "_rct"},     {6'd0, bus.o_rct_fail}, 7'd0);
      chk({tag, "_apt"},     {6'd0, bus.o_apt_fail}, 7'd0);
      chk({tag, "_healthy"}, {6'd0, bus.o_healthy},  7'd0);
      chk({tag, "_win"},     bus.o_win_cnt,          7'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      bus.i_en    = 1'b0;
      bus.i_r     = '0;
      bus.i_clear = 1'b0;
      rst_n       = 1'b0;
      model_reset();
      do_reset();

      // warm-up with a balanced pattern
      for (int i = 0; i < 64; i++) step(1'b1, 2'(i % 4), 1'b0);
      chk("warm_ready",   {6'd0, bus.o_ready},    7'd1);
      chk("warm_healthy", {6'd0, bus.o_healthy},  7'd1);
      chk("warm_rct",     {6'd0, bus.o_rct_fail}, 7'd0);

      // eight repeats of 2'b10 trip the RCT
      for (int i = 0; i < 8; i++) step(1'b1, 2'b10, 1'b0);
      chk("rct_fail",    {6'd0, bus.o_rct_fail}, 7'd1);
      chk("rct_healthy", {6'd0, bus.o_healthy},  7'd0);
      chk("rct_apt",     {6'd0, bus.o_apt_fail}, 7'd0);

      // clear with a concurrent sample: sample discarded
      step(1'b1, 2'b11, 1'b1);
      chk_all_zero("clear");
      step(1'b1, 2'b01, 1'b0);
      chk("after_clear_win", bus.o_win_cnt, 7'd1);
      step(1'b0, 2'b00, 1'b1);

      // idle gaps do not break a run
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 2'b01, 1'b0);
         if (k < 7) for (int g = 0; g < 3; g++) step(1'b0, 2'b00, 1'b0);
      end
      chk("gap_rct", {6'd0, bus.o_rct_fail}, 7'd1);

      // asynchronous reset in the middle of a window
      step(1'b0, 2'b00, 1'b1);
      for (int i = 0; i < 30; i++) step(1'b1, 2'(i % 4), 1'b0);
      chk("mid_win", bus.o_win_cnt, 7'd30);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_all_zero("async");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 63; i++) step(1'b1, 2'(i % 4), 1'b0);
      chk("rewarm_63", {6'd0, bus.o_ready}, 7'd0);
      step(1'b1, 2'b11, 1'b0);
      chk("rewarm_64", {6'd0, bus.o_ready}, 7'd1);

      // APT: 1,1,1,1,1,1,1,0 repeating trips on the 45th sample
      do_reset();
      for (int i = 0; i < 44; i++) step(1'b1, (i % 8 == 7) ? 2'b00 : 2'b01, 1'b0);
      chk("apt_44", {6'd0, bus.o_apt_fail}, 7'd0);
      step(1'b1, 2'b01, 1'b0);
      chk("apt_45",     {6'd0, bus.o_apt_fail}, 7'd1);
      chk("apt_45_rct", {6'd0, bus.o_rct_fail}, 7'd0);
      // frozen in S_FAIL
      step(1'b1, 2'b00, 1'b0);
      step(1'b1, 2'b01, 1'b0);
      chk("fail_frozen_win", bus.o_win_cnt, 7'd45);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
